// File: rtl/inst_encoder.sv
// RV32I field-level instruction encoder: range-checks and packs a request,
// buffers the encoded word in a small FIFO and streams it with a word address.
module inst_encoder #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [2:0]        in_func3,
  input  logic              in_alt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_cnt
);

  typedef enum logic [2:0] {
    CL_R    = 3'd0,
    CL_I    = 3'd1,
    CL_LW   = 3'd2,
    CL_JALR = 3'd3,
    CL_SW   = 3'd4,
    CL_B    = 3'd5,
    CL_U    = 3'd6,
    CL_J    = 3'd7
  } cls_e;

  localparam int unsigned       PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    FULL_C = (PTR_W+1)'(FIFO_DEPTH);

  cls_e        w_cls;
  logic [31:0] w_word;
  logic        w_ok;
  logic        w_shift;
  logic        w_fits12;
  logic        w_fits13;
  logic        w_fits21;
  logic [6:0]  w_f7;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_reject;

  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W:0]    r_count;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic [7:0]        r_err_cnt;

  assign w_cls   = cls_e'(in_class);
  assign w_shift = (in_func3 == 3'b001) || (in_func3 == 3'b101);

  // Signed range checks: all bits above the field's sign bit must match it.
  assign w_fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign w_fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign w_fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    w_word = '0;
    w_ok   = 1'b1;
    w_f7   = in_alt ? 7'b0100000 : 7'b0000000;
    case (w_cls)
      CL_R: begin
        w_word = {w_f7, in_rs2, in_rs1, in_func3, in_rd, 7'b0110011};
      end
      CL_I: begin
        if (w_shift) begin
          // alt only selects SRAI; SLLI always carries a zero func7
          w_ok   = ~(|in_imm[31:5]);
          w_word = {(in_func3 == 3'b101) ? w_f7 : 7'b0000000, in_imm[4:0],
                    in_rs1, in_func3, in_rd, 7'b0010011};
        end else begin
          w_ok   = w_fits12;
          w_word = {in_imm[11:0], in_rs1, in_func3, in_rd, 7'b0010011};
        end
      end
      CL_LW: begin
        w_ok   = w_fits12;
        w_word = {in_imm[11:0], in_rs1, in_func3, in_rd, 7'b0000011};
      end
      CL_JALR: begin
        w_ok   = w_fits12;
        w_word = {in_imm[11:0], in_rs1, in_func3, in_rd, 7'b1100111};
      end
      CL_SW: begin
        w_ok   = w_fits12;
        w_word = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], 7'b0100011};
      end
      CL_B: begin
        w_ok   = w_fits13 & ~in_imm[0];
        w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                  in_imm[4:1], in_imm[11], 7'b1100011};
      end
      CL_U: begin
        w_ok   = ~(|in_imm[11:0]);
        w_word = {in_imm[31:12], in_rd, 7'b0110111};
      end
      CL_J: begin
        w_ok   = w_fits21 & ~in_imm[0];
        w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                  in_rd, 7'b1101111};
      end
      default: begin
        w_word = '0;
        w_ok   = 1'b1;
      end
    endcase
  end

  assign in_ready  = (r_count != FULL_C);
  assign out_valid = (r_count != '0);
  assign out_inst  = out_valid ? r_mem[r_rptr] : '0;
  assign out_addr  = r_addr;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

  assign w_accept = in_valid & in_ready;
  assign w_push   = w_accept & w_ok;
  assign w_reject = w_accept & ~w_ok;
  assign w_pop    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_addr    <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
        r_addr <= r_addr + ADDR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      r_err <= w_reject;
      if (w_reject && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: fixed encoding vectors, handshake
// corner sequences and a randomized run against a queue-based reference model.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_class;
  logic [2:0]  in_func3;
  logic        in_alt;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_ready;

  logic        in_ready,  in_ready2;
  logic        out_valid, out_valid2;
  logic [31:0] out_inst,  out_inst2;
  logic [9:0]  out_addr;
  logic [1:0]  out_addr2;
  logic        err,       err2;
  logic [7:0]  err_cnt,   err_cnt2;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(10), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_func3(in_func3), .in_alt(in_alt),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .err(err), .err_cnt(err_cnt)
  );

  inst_encoder #(.ADDR_W(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_class(in_class), .in_func3(in_func3), .in_alt(in_alt),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_inst(out_inst2),
    .out_addr(out_addr2), .err(err2), .err_cnt(err_cnt2)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  int unsigned m_addr;
  int unsigned m_errcnt;
  bit          m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: field placement by arithmetic shifts, ranges by signed compare.
  function automatic logic [32:0] ref_enc(input logic [2:0] c, input logic [2:0] f3,
                                          input logic alt, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [31:0] imm);
    longint      si = longint'($signed(imm));
    int unsigned ui = imm;
    int unsigned RD = rd;
    int unsigned R1 = rs1;
    int unsigned R2 = rs2;
    int unsigned F3 = f3;
    int unsigned w  = 0;
    bit          ok = 1'b1;
    bit          fit12 = (si >= -2048) && (si <= 2047);
    case (c)
      3'd0: w = (alt ? 32'h4000_0000 : 0) + (R2 << 20) + (R1 << 15) + (F3 << 12) + (RD << 7) + 'h33;
      3'd1: begin
        if (F3 == 1 || F3 == 5) begin
          ok = (ui >> 5) == 0;
          w  = ((F3 == 5 && alt) ? 32'h4000_0000 : 0) + ((ui & 31) << 20) +
               (R1 << 15) + (F3 << 12) + (RD << 7) + 'h13;
        end else begin
          ok = fit12;
          w  = ((ui & 'hFFF) << 20) + (R1 << 15) + (F3 << 12) + (RD << 7) + 'h13;
        end
      end
      3'd2: begin ok = fit12; w = ((ui & 'hFFF) << 20) + (R1 << 15) + (F3 << 12) + (RD << 7) + 'h03; end
      3'd3: begin ok = fit12; w = ((ui & 'hFFF) << 20) + (R1 << 15) + (F3 << 12) + (RD << 7) + 'h67; end
      3'd4: begin
        ok = fit12;
        w  = (((ui >> 5) & 127) << 25) + (R2 << 20) + (R1 << 15) + (F3 << 12) + ((ui & 31) << 7) + 'h23;
      end
      3'd5: begin
        ok = (si >= -4096) && (si <= 4094) && (ui % 2 == 0);
        w  = (((ui >> 12) & 1) << 31) + (((ui >> 5) & 63) << 25) + (R2 << 20) + (R1 << 15) +
             (F3 << 12) + (((ui >> 1) & 15) << 8) + (((ui >> 11) & 1) << 7) + 'h63;
      end
      3'd6: begin ok = (ui % 4096) == 0; w = (ui & 'hFFFF_F000) + (RD << 7) + 'h37; end
      default: begin
        ok = (si >= -1048576) && (si <= 1048574) && (ui % 2 == 0);
        w  = (((ui >> 20) & 1) << 31) + (((ui >> 1) & 1023) << 21) + (((ui >> 11) & 1) << 20) +
             (((ui >> 12) & 255) << 12) + (RD << 7) + 'h6F;
      end
    endcase
    return {ok, w};
  endfunction

  task automatic model_edge();
    bit acc;
    bit pop;
    logic [32:0] e;
    if (rst) begin
      mq.delete();
      m_addr   = 0;
      m_err    = 1'b0;
      m_errcnt = 0;
    end else begin
      acc = in_valid && (mq.size() < 4);
      pop = (mq.size() > 0) && out_ready;
      e   = ref_enc(in_class, in_func3, in_alt, in_rd, in_rs1, in_rs2, in_imm);
      if (pop) begin
        void'(mq.pop_front());
        m_addr = (m_addr + 1) % 1024;
      end
      if (acc && e[32]) mq.push_back(e[31:0]);
      m_err = acc && !e[32];
      if (m_err && m_errcnt < 255) m_errcnt++;
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_inst;
    exp_inst = (mq.size() > 0) ? mq[0] : 32'h0;
    chk("in_ready",   in_ready,   mq.size() != 4);
    chk("out_valid",  out_valid,  mq.size() != 0);
    chk("out_inst",   out_inst,   exp_inst);
    chk("out_addr",   out_addr,   m_addr);
    chk("err",        err,        m_err);
    chk("err_cnt",    err_cnt,    m_errcnt);
    chk("in_ready2",  in_ready2,  mq.size() != 4);
    chk("out_valid2", out_valid2, mq.size() != 0);
    chk("out_inst2",  out_inst2,  exp_inst);
    chk("out_addr2",  out_addr2,  m_addr % 4);
    chk("err2",       err2,       m_err);
    chk("err_cnt2",   err_cnt2,   m_errcnt);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_req(input logic [2:0] c, input logic [2:0] f3, input logic alt,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
    in_valid = 1'b1;
    in_class = c;
    in_func3 = f3;
    in_alt   = alt;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_imm();
    int v;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: begin v = int'($urandom_range(0, 255)) - 128; return v; end
      2: begin
        case ($urandom_range(0, 16))
          0: v = 2047;     1: v = 2048;      2: v = -2048;    3: v = -2049;
          4: v = 4094;     5: v = 4095;      6: v = 4096;     7: v = -4096;
          8: v = -4098;    9: v = 1048574;   10: v = 1048576; 11: v = -1048576;
          12: v = -1048578; 13: v = 31;      14: v = 32;      15: v = 'h1001;
          default: v = 'h12345000;
        endcase
        return v;
      end
      default: return $urandom & 32'hFFFF_F000;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  cls;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        ok;
    logic [31:0] word;
  } vec_t;

  vec_t vt[19];

  initial begin
    int rej;
    int n;

    vt[0]  = '{3'd1, 3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'd5,          1'b1, 32'h00500093};
    vt[1]  = '{3'd0, 3'd0, 1'b1, 5'd3,  5'd1, 5'd2, 32'd0,          1'b1, 32'h402081B3};
    vt[2]  = '{3'd5, 3'd0, 1'b0, 5'd0,  5'd1, 5'd2, 32'hFFFFFFF8,   1'b1, 32'hFE208CE3};
    vt[3]  = '{3'd7, 3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'h00000800,   1'b1, 32'h001000EF};
    vt[4]  = '{3'd5, 3'd0, 1'b0, 5'd0,  5'd1, 5'd2, 32'd3,          1'b0, 32'h0};
    vt[5]  = '{3'd1, 3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'd2048,       1'b0, 32'h0};
    vt[6]  = '{3'd6, 3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'h00001001,   1'b0, 32'h0};
    vt[7]  = '{3'd2, 3'd2, 1'b0, 5'd5,  5'd2, 5'd0, 32'hFFFFFFFC,   1'b1, 32'hFFC12283};
    vt[8]  = '{3'd4, 3'd2, 1'b0, 5'd0,  5'd2, 5'd5, 32'd8,          1'b1, 32'h00512423};
    vt[9]  = '{3'd6, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'h12345000,   1'b1, 32'h12345537};
    vt[10] = '{3'd1, 3'd5, 1'b1, 5'd1,  5'd1, 5'd0, 32'd3,          1'b1, 32'h4030D093};
    vt[11] = '{3'd1, 3'd5, 1'b0, 5'd1,  5'd1, 5'd0, 32'd32,         1'b0, 32'h0};
    vt[12] = '{3'd3, 3'd0, 1'b0, 5'd0,  5'd1, 5'd0, 32'd0,          1'b1, 32'h00008067};
    vt[13] = '{3'd7, 3'd0, 1'b0, 5'd0,  5'd0, 5'd0, 32'hFFF00000,   1'b1, 32'h8000006F};
    vt[14] = '{3'd5, 3'd0, 1'b0, 5'd0,  5'd0, 5'd0, 32'h00000FFE,   1'b1, 32'h7E000FE3};
    vt[15] = '{3'd1, 3'd1, 1'b1, 5'd1,  5'd1, 5'd0, 32'd1,          1'b1, 32'h00109093};
    vt[16] = '{3'd7, 3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'h00100000,   1'b0, 32'h0};
    vt[17] = '{3'd5, 3'd0, 1'b0, 5'd0,  5'd1, 5'd2, 32'h00001000,   1'b0, 32'h0};
    vt[18] = '{3'd1, 3'd0, 1'b0, 5'd0,  5'd0, 5'd0, 32'hFFFFF800,   1'b1, 32'h80000013};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_req(3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    in_valid = 1'b0;
    do_reset();
    do_reset();

    // Table: one request at a time into an empty FIFO, popped the next cycle.
    rej = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      set_req(vt[i].cls, vt[i].f3, vt[i].alt, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm);
      cycle();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_err", i), err, !vt[i].ok);
      chk($sformatf("vec%0d_valid", i), out_valid, vt[i].ok);
      if (!vt[i].ok) rej++;
      chk($sformatf("vec%0d_errcnt", i), err_cnt, rej);
      if (vt[i].ok) chk($sformatf("vec%0d_word", i), out_inst, vt[i].word);
      cycle();
    end

    // Back-to-back rejects give consecutive err cycles.
    set_req(3'd5, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd1);
    cycle();
    chk("b2b_err1", err, 1'b1);
    set_req(3'd6, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd7);
    cycle();
    chk("b2b_err2", err, 1'b1);
    in_valid = 1'b0;
    cycle();
    chk("b2b_err3", err, 1'b0);

    // Backpressure: fill, hold, then drain in order.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(3'd1, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i + 10));
      cycle();
    end
    chk("bp_full_ready", in_ready, 1'b0);
    set_req(3'd1, 3'd0, 1'b0, 5'd9, 5'd0, 5'd0, 32'd99);
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("bp_ready_after_pop", in_ready, 1'b1);
    chk("bp_addr1", out_addr, 32'd1);
    chk("bp_head2", out_inst, 32'h00B00113);
    n = 0;
    while (mq.size() > 0 && n < 10) begin cycle(); n++; end
    chk("bp_drained", out_valid, 1'b0);
    chk("bp_addr4", out_addr, 32'd4);

    // Narrow address counter wraps after 4 pops.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_req(3'd6, 3'd0, 1'b0, 5'(i), 5'd0, 5'd0, 32'h0000_1000);
      cycle();
      in_valid = 1'b0;
      chk($sformatf("wrap_addr%0d", i), out_addr2, 32'(i % 4));
      cycle();
    end

    // Reset with words buffered, a nonzero address and a nonzero err_cnt.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_req(3'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd1);
      cycle();
    end
    set_req(3'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd5000);
    cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(3'd0, 3'd0, 1'b0, 5'(i), 5'd1, 5'd2, 32'd0);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("pre_rst_addr", out_addr, 32'd2);
    chk("pre_rst_errcnt", err_cnt, 32'd1);
    rst = 1'b1;
    set_req(3'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd3);
    out_ready = 1'b1;
    cycle();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_addr", out_addr, 32'd0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_errcnt", err_cnt, 32'd0);

    // err_cnt saturation.
    set_req(3'd6, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd1);
    for (int i = 0; i < 260; i++) cycle();
    in_valid = 1'b0;
    cycle();
    chk("sat_errcnt", err_cnt, 32'd255);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      set_req(3'($urandom_range(0, 7)), 3'($urandom), 1'($urandom), 5'($urandom),
              5'($urandom), 5'($urandom), rnd_imm());
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      cycle();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
